data_axi_bridge: RTL and testbench

DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

---
 rtl/mycpu_pkg.sv | 26 ++
 rtl/data_axi_bridge.sv | 126 ++++++++++++
 tb/tb_data_axi_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the MEM-stage sram_like to AXI bridge: FSM states, size codes, strobe decode.
package mycpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Reserved size 3 yields no strobes; the bus cycle still runs to completion.
    function automatic logic [3:0] wstrb_decode(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_axi_bridge.sv
// sram_like data port to single-beat AXI bridge, one outstanding transaction.
// Latency 3 cycles accept-to-data_data_ok with a zero-wait slave; stalls on any AXI ready/valid, accepts only in IDLE.
module data_axi_bridge
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    bridge_state_t state_q, state_d;
    logic [31:0]   addr_q, wdata_q;
    logic [1:0]    size_q;
    logic          wr_q;
    logic          aw_done, w_done;
    logic          aw_fire, w_fire, wr_all_done;
    logic          rd_fire, b_fire;

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_decode(size_q, addr_q[1:0]);

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign wr_all_done = (aw_done || aw_fire) && (w_done || w_fire);
    assign rd_fire     = rready && rvalid;
    assign b_fire      = bready && bvalid;

    always_comb begin
        state_d      = state_q;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    state_d      = data_wr ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                arvalid = !wr_q;
                if (arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                rready = 1'b1;
                if (rvalid) state_d = ST_IDLE;
            end
            ST_WADDR: begin
                // Address and data channels retire independently; leave only once both have.
                awvalid = wr_q && !aw_done;
                wvalid  = wr_q && !w_done;
                if (wr_all_done) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                bready = 1'b1;
                if (bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            wr_q         <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            data_data_ok <= 1'b0;
            data_rdata   <= '0;
        end else begin
            state_q      <= state_d;
            data_data_ok <= rd_fire || b_fire;
            if (data_addr_ok) begin
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                size_q  <= data_size;
                wr_q    <= data_wr;
            end
            if (rd_fire) data_rdata <= rdata;
            if (state_q == ST_WADDR) begin
                if (wr_all_done) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: drives on the falling edge, samples 1ns later.
module tb_data_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    int n_chk  = 0;
    int n_pass = 0;
    int n_aok  = 0;

    always #5 clk = ~clk;

    data_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic smp();
        #1;
    endtask

    initial begin
        resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = '0; data_wdata = '0; rdata = '0;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        cyc(); cyc();
        smp();
        check("rst_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        check("rst_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("rst_valids", {28'b0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
        check("rst_readys", {30'b0, rready, bready}, 32'd0);
        check("rst_rdata", data_rdata, 32'd0);
        resetn = 1'b1;

        // Load word, zero-wait slave
        cyc(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1004; smp();
        check("ld_addr_ok_c0", {31'b0, data_addr_ok}, 32'd1);
        cyc(); data_req = 1'b0; data_addr = 32'hFFFF_FFFF; arready = 1'b1; smp();
        check("ld_arvalid_c1", {31'b0, arvalid}, 32'd1);
        check("ld_araddr", araddr, 32'h0000_1004);
        check("ld_arsize", {29'b0, arsize}, 32'd2);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; smp();
        check("ld_rready_c2", {30'b0, rready, arvalid}, 32'd2);
        check("ld_no_early_ok", {31'b0, data_data_ok}, 32'd0);
        cyc(); rvalid = 1'b0; rdata = 32'h0; smp();
        check("ld_data_ok_c3", {31'b0, data_data_ok}, 32'd1);
        check("ld_rdata", data_rdata, 32'hDEAD_BEEF);
        cyc(); smp();
        check("ld_ok_single", {31'b0, data_data_ok}, 32'd0);

        // Store byte at offset 3
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h0000_2003; data_wdata = 32'h5500_0000; smp();
        check("sb_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        cyc(); data_req = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_size = 2'd2;
        awready = 1'b1; wready = 1'b1; smp();
        check("sb_aw_w_valid", {30'b0, awvalid, wvalid}, 32'd3);
        check("sb_awaddr", awaddr, 32'h0000_2003);
        check("sb_awsize", {29'b0, awsize}, 32'd0);
        check("sb_wstrb", {28'b0, wstrb}, 32'h8);
        check("sb_wdata", wdata, 32'h5500_0000);
        check("sb_bready_c1", {31'b0, bready}, 32'd0);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; smp();
        check("sb_bready_c2", {29'b0, bready, awvalid, wvalid}, 32'd4);
        cyc(); bvalid = 1'b0; smp();
        check("sb_data_ok", {31'b0, data_data_ok}, 32'd1);
        cyc(); smp();
        check("sb_ok_single", {31'b0, data_data_ok}, 32'd0);

        // Store halfword, awready three cycles after wready
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h0000_3002; data_wdata = 32'h1234_0000; smp();
        cyc(); data_req = 1'b0; wready = 1'b1; smp();
        check("sh_both_valid", {30'b0, awvalid, wvalid}, 32'd3);
        check("sh_wstrb", {28'b0, wstrb}, 32'hC);
        cyc(); wready = 1'b0; smp();
        check("sh_w_dropped", {29'b0, awvalid, wvalid, bready}, 32'd4);
        cyc(); smp();
        check("sh_aw_held", {29'b0, awvalid, wvalid, bready}, 32'd4);
        cyc(); awready = 1'b1; smp();
        check("sh_aw_fire", {29'b0, awvalid, wvalid, bready}, 32'd4);
        cyc(); awready = 1'b0; bvalid = 1'b1; smp();
        check("sh_bready", {29'b0, awvalid, wvalid, bready}, 32'd1);
        cyc(); bvalid = 1'b0; smp();
        check("sh_data_ok", {31'b0, data_data_ok}, 32'd1);

        // Reserved size: no strobes, still completes
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd3; data_addr = 32'h0000_4000; smp();
        cyc(); data_req = 1'b0; awready = 1'b1; wready = 1'b1; smp();
        check("rsv_wstrb", {28'b0, wstrb}, 32'h0);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; smp();
        cyc(); bvalid = 1'b0; smp();
        check("rsv_data_ok", {31'b0, data_data_ok}, 32'd1);

        // Two loads with data_req held high
        cyc(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0100; smp();
        if (data_addr_ok) n_aok++;
        cyc(); arready = 1'b1; smp();
        if (data_addr_ok) n_aok++;
        check("b2b_araddr1", araddr, 32'h0000_0100);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111; smp();
        if (data_addr_ok) n_aok++;
        cyc(); rvalid = 1'b0; data_addr = 32'h0000_0200; smp();
        if (data_addr_ok) n_aok++;
        check("b2b_ok_and_accept", {30'b0, data_data_ok, data_addr_ok}, 32'd3);
        check("b2b_rdata1", data_rdata, 32'h1111_1111);
        cyc(); data_req = 1'b0; arready = 1'b1; smp();
        if (data_addr_ok) n_aok++;
        check("b2b_araddr2", araddr, 32'h0000_0200);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222; smp();
        cyc(); rvalid = 1'b0; smp();
        if (data_addr_ok) n_aok++;
        check("b2b_rdata2", data_rdata, 32'h2222_2222);
        check("b2b_accept_count", n_aok, 32'd2);

        // Reset while waiting for read data
        cyc(); data_req = 1'b1; data_addr = 32'h0000_0300; smp();
        cyc(); data_req = 1'b0; arready = 1'b1; smp();
        cyc(); arready = 1'b0; smp();
        check("rst_mid_rready", {31'b0, rready}, 32'd1);
        cyc(); resetn = 1'b0; smp();
        check("rst_mid_outs", {26'b0, rready, arvalid, awvalid, wvalid, bready, data_data_ok}, 32'd0);
        check("rst_mid_rdata", data_rdata, 32'd0);
        cyc(); resetn = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_BAD0; smp();
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            check("rst_no_reissue", {29'b0, data_data_ok, rready, arvalid}, 32'd0);
        end
        rvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
